// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle for serial_adder_fsm; sub exists only with SERIAL_ADDER_SUB_EN
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             ser_sum;
   logic             ser_carry;
   modport master (
      output start, op_a, op_b,
`ifdef SERIAL_ADDER_SUB_EN
      output sub,
`endif
      input  busy, done, result, cout, ser_sum, ser_carry
   );
   modport slave (
      input  start, op_a, op_b,
`ifdef SERIAL_ADDER_SUB_EN
      input  sub,
`endif
      output busy, done, result, cout, ser_sum, ser_carry
   );
endinterface

// File: rtl/serial_adder_fsm.sv
// serial_adder_fsm: LSB-first bit-serial adder with a registered Mealy carry stage
// SERIAL_ADDER_SUB_EN adds a sub input (op_a - op_b via ~op_b and carry-in 1)
module serial_adder_fsm #(
   parameter int WIDTH = 8
) (
   input logic           clk,
   input logic           rst,
   serial_adder_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_a, r_b, r_result;
   logic [CW-1:0]    r_cnt;
   logic             r_carry, r_cout;
   logic             w_sub, w_last, w_sum, w_carry, w_load;
`ifdef SERIAL_ADDER_SUB_EN
   assign w_sub = bus.sub;
`else
   assign w_sub = 1'b0;
`endif
   always_comb begin
      w_next  = r_state;
      w_sum   = 1'b0;
      w_carry = 1'b0;
      w_last  = r_cnt == CW'(WIDTH - 1);
      w_load  = r_state == IDLE && bus.start;
      if (r_state == SHIFT) begin
         w_sum   = r_a[0] ^ r_b[0] ^ r_carry;
         w_carry = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
      end
      w_next = (r_state == IDLE) ? (bus.start ? SHIFT : IDLE) :
               (r_state == SHIFT) ? (w_last ? DONE : SHIFT) : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
      end else if (w_load) begin
         r_a     <= bus.op_a;
         r_b     <= w_sub ? ~bus.op_b : bus.op_b;
         r_carry <= w_sub;
         r_cnt   <= '0;
      end else if (r_state == SHIFT) begin
         r_carry  <= w_carry;
         r_result <= {w_sum, r_result[WIDTH-1:1]};
         r_a      <= r_a >> 1;
         r_b      <= r_b >> 1;
         r_cnt    <= r_cnt + CW'(1);
         if (w_last) r_cout <= w_carry;
      end
   end
   assign bus.busy      = r_state != IDLE;
   assign bus.done      = r_state == DONE;
   assign bus.result    = r_result;
   assign bus.cout      = r_cout;
   assign bus.ser_sum   = w_sum;
   assign bus.ser_carry = w_carry;
endmodule

// File: tb/tb_serial_adder_fsm.sv
// tb_serial_adder_fsm: directed scoreboard bench for serial_adder_fsm (WIDTH=8)
module tb_serial_adder_fsm;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;
   int   n_done = 0;
   logic [8:0] sb[$];
   serial_adder_if #(.WIDTH(8)) bus ();
   serial_adder_fsm #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s, input bit push);
      logic [8:0] e;
      e = s ? {1'b0, a} + {1'b0, ~b} + 9'd1 : {1'b0, a} + {1'b0, b};
      bus.op_a = a;
      bus.op_b = b;
`ifdef SERIAL_ADDER_SUB_EN
      bus.sub = s;
`endif
      bus.start = 1'b1;
      if (push) sb.push_back(e);
      step();
      bus.start = 1'b0;
   endtask
   task automatic wait_done(output int n);
      n = 0;
      while (bus.done !== 1'b1 && n < 30) begin
         step();
         n++;
      end
      chk("done_seen", bus.done, 1);
   endtask
   always @(negedge clk) begin
      if (!rst && bus.done === 1'b1) begin
         logic [8:0] e;
         n_done++;
         chk("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("result", bus.result, e[7:0]);
            chk("cout", bus.cout, e[8]);
         end
      end
   end
   initial begin
      int n;
      int d0;
      logic [7:0] s;
      bus.start = 1'b0;
      bus.op_a = '0;
      bus.op_b = '0;
`ifdef SERIAL_ADDER_SUB_EN
      bus.sub = 1'b0;
`endif
      step();
      step();
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_cout", bus.cout, 0);
      chk("rst_ser_sum", bus.ser_sum, 0);
      chk("rst_ser_carry", bus.ser_carry, 0);
      rst = 1'b0;
      step();
      // basic add with ser_sum trace and 9-cycle latency
      start_op(8'h0F, 8'h01, 1'b0, 1'b1);
      chk("busy_after_start", bus.busy, 1);
      s = 8'h0F + 8'h01;
      for (int i = 0; i < 8; i++) begin
         chk("ser_sum_trace", bus.ser_sum, s[i]);
         chk("no_early_done", bus.done, 0);
         step();
      end
      chk("latency_done", bus.done, 1);
      chk("busy_in_done", bus.busy, 1);
      step();
      chk("done_one_cycle", bus.done, 0);
      chk("idle_busy", bus.busy, 0);
      chk("idle_ser_sum", bus.ser_sum, 0);
      // overflow
      start_op(8'hFF, 8'h01, 1'b0, 1'b1);
      wait_done(n);
      step();
      // no carry ever generated
      start_op(8'hAA, 8'h55, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         chk("aa55_carry_zero", bus.ser_carry, 0);
         step();
      end
      chk("aa55_done", bus.done, 1);
      step();
      // start while busy is ignored
      d0 = n_done;
      start_op(8'h03, 8'h04, 1'b0, 1'b1);
      step();
      step();
      start_op(8'h10, 8'h10, 1'b0, 1'b0);
      wait_done(n);
      repeat (14) step();
      chk("busy_start_one_done", n_done - d0, 1);
      chk("result_held", bus.result, 8'h07);
      // reset mid-operation
      d0 = n_done;
      start_op(8'h80, 8'h80, 1'b0, 1'b0);
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_result", bus.result, 0);
      chk("midrst_cout", bus.cout, 0);
      repeat (12) step();
      chk("midrst_no_done", n_done - d0, 0);
      start_op(8'h01, 8'h02, 1'b0, 1'b1);
      wait_done(n);
      chk("post_rst_latency", n + 1, 9);
      step();
      // back-to-back
      start_op(8'h11, 8'h22, 1'b0, 1'b1);
      wait_done(n);
      step();
      chk("b2b_idle", bus.busy, 0);
      start_op(8'hF0, 8'h20, 1'b0, 1'b1);
      wait_done(n);
      chk("b2b_gap", n + 2, 10);
      step();
`ifdef SERIAL_ADDER_SUB_EN
      start_op(8'h05, 8'h07, 1'b1, 1'b1);
      wait_done(n);
      step();
      start_op(8'h07, 8'h05, 1'b1, 1'b1);
      wait_done(n);
      step();
`endif
      step();
      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
